// File: rtl/ppt_sequencer_if.sv
// Register-bus interface between the I2C slave front end and ppt_sequencer.
//   reg_wr_en  : single-cycle write strobe (master -> slave)
//   reg_rd_en  : single-cycle read strobe (master -> slave)
//   reg_addr   : register address (master -> slave)
//   reg_wdata  : write data (master -> slave)
//   reg_rdata  : registered read data (slave -> master)
interface ppt_sequencer_if #(
  parameter int ADDR_W = 4
) ();
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;

  modport master (
    output reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/ppt_sequencer.sv
// Programmable pulse-train sequencer. A byte-wide register bank sets up
// PERIOD/WIDTH/COUNT. Writing CTRL.RUN=1 starts a train of COUNT pulses, each
// WIDTH cycles high within a PERIOD-cycle frame.
//   clk       : system clock (32.768 kHz)
//   rst       : asynchronous active-high reset
//   bus       : register bus (slave modport of ppt_sequencer_if)
//   pulse_out : pulse train output
//   busy      : high while a train is in progress
//   done      : sticky completion flag (STATUS[0])
module ppt_sequencer #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  ppt_sequencer_if.slave  bus,
  output logic            pulse_out,
  output logic            busy,
  output logic            done
);

  localparam logic [ADDR_W-1:0] A_PER_H  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PER_L  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_WID_H  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_WID_L  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CNT_H  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CNT_L  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_CD_H   = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_CD_L   = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(10);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   period_r, width_r, count_r;
  logic [CNT_W-1:0]   sh_period_r, sh_width_r, sh_count_r;
  logic [CNT_W-1:0]   phase_r, cnt_done_r;
  logic [7:0]         snap_r, rdata_r, rd_mux_s;
  logic               run_r, done_r, cfg_err_r, pulse_r, busy_r;
  logic               pulse_nxt_s, busy_nxt_s;
  logic               ctrl_wr_s, status_wr_s, active_s, cfg_ok_s;
  logic               start_s, start_ok_s, abort_s, frame_end_s, last_s, finish_s;

  assign active_s    = (state_r != ST_IDLE);
  assign ctrl_wr_s   = bus.reg_wr_en && (bus.reg_addr == A_CTRL);
  assign status_wr_s = bus.reg_wr_en && (bus.reg_addr == A_STATUS);
  assign cfg_ok_s    = (period_r >= CNT_W'(2)) && (width_r >= CNT_W'(1)) &&
                       (width_r < period_r) && (count_r >= CNT_W'(1));
  assign start_s     = ctrl_wr_s && bus.reg_wdata[0] && !active_s;
  assign start_ok_s  = start_s && cfg_ok_s;
  assign abort_s     = ctrl_wr_s && !bus.reg_wdata[0] && active_s;
  assign frame_end_s = (state_r == ST_LOW) && (phase_r == sh_period_r - CNT_W'(1));
  // COUNT_DONE never exceeds COUNT, so the 16-bit increment cannot wrap here.
  assign last_s      = ((cnt_done_r + CNT_W'(1)) == sh_count_r);
  // An abort in the same cycle as a frame end wins: no count, no completion.
  assign finish_s    = frame_end_s && last_s && !abort_s;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_nxt_s = ST_HIGH;
        else            state_nxt_s = ST_IDLE;
      end
      ST_HIGH: begin
        if (abort_s)                                       state_nxt_s = ST_IDLE;
        else if (phase_r == sh_width_r - CNT_W'(1))        state_nxt_s = ST_LOW;
        else                                               state_nxt_s = ST_HIGH;
      end
      ST_LOW: begin
        if (abort_s || finish_s) state_nxt_s = ST_IDLE;
        else if (frame_end_s)    state_nxt_s = ST_HIGH;
        else                     state_nxt_s = ST_LOW;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode from the next state so the outputs can be registered
  always_comb begin
    pulse_nxt_s = 1'b0;
    busy_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_HIGH: begin pulse_nxt_s = 1'b1; busy_nxt_s = 1'b1; end
      ST_LOW:  begin pulse_nxt_s = 1'b0; busy_nxt_s = 1'b1; end
      default: begin pulse_nxt_s = 1'b0; busy_nxt_s = 1'b0; end
    endcase
  end

  // Output registers; async reset drops pulse_out immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      pulse_r <= pulse_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Read-data multiplexer over current (pre-write) register values
  always_comb begin
    rd_mux_s = 8'h00;
    case (bus.reg_addr)
      A_PER_H:  rd_mux_s = period_r[CNT_W-1:8];
      A_PER_L:  rd_mux_s = period_r[7:0];
      A_WID_H:  rd_mux_s = width_r[CNT_W-1:8];
      A_WID_L:  rd_mux_s = width_r[7:0];
      A_CNT_H:  rd_mux_s = count_r[CNT_W-1:8];
      A_CNT_L:  rd_mux_s = count_r[7:0];
      A_CTRL:   rd_mux_s = {7'd0, run_r};
      A_CD_H:   rd_mux_s = cnt_done_r[CNT_W-1:8];
      A_CD_L:   rd_mux_s = snap_r;
      A_STATUS: rd_mux_s = {5'd0, cfg_err_r, active_s, done_r};
      default:  rd_mux_s = 8'h00;
    endcase
  end

  // Register bank, read port, train counters and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_r    <= '0;
      width_r     <= '0;
      count_r     <= '0;
      sh_period_r <= '0;
      sh_width_r  <= '0;
      sh_count_r  <= '0;
      phase_r     <= '0;
      cnt_done_r  <= '0;
      snap_r      <= 8'h00;
      rdata_r     <= 8'h00;
      run_r       <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      // Configuration is frozen while a train runs.
      if (bus.reg_wr_en && !active_s) begin
        case (bus.reg_addr)
          A_PER_H: period_r[CNT_W-1:8] <= bus.reg_wdata;
          A_PER_L: period_r[7:0]       <= bus.reg_wdata;
          A_WID_H: width_r[CNT_W-1:8]  <= bus.reg_wdata;
          A_WID_L: width_r[7:0]        <= bus.reg_wdata;
          A_CNT_H: count_r[CNT_W-1:8]  <= bus.reg_wdata;
          A_CNT_L: count_r[7:0]        <= bus.reg_wdata;
          default: ;
        endcase
      end

      // Reading the high byte snapshots the low byte for a coherent pair.
      if (bus.reg_rd_en) begin
        rdata_r <= rd_mux_s;
        if (bus.reg_addr == A_CD_H) snap_r <= cnt_done_r[7:0];
      end

      if (start_ok_s) begin
        sh_period_r <= period_r;
        sh_width_r  <= width_r;
        sh_count_r  <= count_r;
      end

      if (start_ok_s)               run_r <= 1'b1;
      else if (abort_s || finish_s) run_r <= 1'b0;

      if (start_s && !cfg_ok_s)                    cfg_err_r <= 1'b1;
      else if (status_wr_s && bus.reg_wdata[2])    cfg_err_r <= 1'b0;

      // Completion beats a simultaneous W1C clear.
      if (finish_s)                                done_r <= 1'b1;
      else if (start_ok_s)                         done_r <= 1'b0;
      else if (status_wr_s && bus.reg_wdata[0])    done_r <= 1'b0;

      if (start_ok_s)                        cnt_done_r <= '0;
      else if (frame_end_s && !abort_s)      cnt_done_r <= cnt_done_r + CNT_W'(1);

      if (start_ok_s)       phase_r <= '0;
      else if (frame_end_s) phase_r <= '0;
      else if (active_s)    phase_r <= phase_r + CNT_W'(1);
    end
  end

  assign bus.reg_rdata = rdata_r;
  assign pulse_out     = pulse_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_ppt_sequencer.sv
// Self-checking bench for ppt_sequencer. Register reads push their expected
// value into a scoreboard queue; a monitor pops and compares after each read
// edge. Pulse-train shape is checked cycle by cycle against PERIOD/WIDTH.
module tb_ppt_sequencer;
  logic clk;
  logic rst;
  logic pulse_out, busy, done;

  ppt_sequencer_if #(.ADDR_W(4)) bus ();

  ppt_sequencer #(.CNT_W(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    string      name;
    logic [7:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge after the write edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.reg_wr_en = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    @(negedge clk);
    bus.reg_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string name);
    rd_exp_t t;
    t.name = name;
    t.exp  = e;
    sb_q.push_back(t);
    bus.reg_rd_en = 1'b1;
    bus.reg_addr  = a;
    @(negedge clk);
    bus.reg_rd_en = 1'b0;
  endtask

  // Scoreboard monitor: compare read data just after each read edge
  always @(posedge clk) begin
    if (bus.reg_rd_en && !rst) begin
      rd_exp_t t;
      #1;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got 0x%02h expected no read", bus.reg_rdata);
      end else begin
        t = sb_q.pop_front();
        if (bus.reg_rdata !== t.exp) begin
          errors++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", t.name, bus.reg_rdata, t.exp);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int k;
    int mism;
    rst = 1'b1;
    bus.reg_wr_en = 1'b0;
    bus.reg_rd_en = 1'b0;
    bus.reg_addr  = 4'd0;
    bus.reg_wdata = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_pulse", pulse_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rdata", bus.reg_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 11; a++) rd(4'(a), 8'h00, "reset_reg");

    // Full train: PERIOD=32, WIDTH=4, COUNT=50
    wr(4'd0, 8'h00); wr(4'd1, 8'd32);
    wr(4'd2, 8'h00); wr(4'd3, 8'd4);
    wr(4'd4, 8'h00); wr(4'd5, 8'd50);
    wr(4'd7, 8'h01);
    check("start_busy", busy, 1);
    k = 0; mism = 0;
    while (busy && k < 5000) begin
      if (pulse_out !== ((k % 32) < 4)) mism++;
      k++;
      @(negedge clk);
    end
    check("train_busy_cycles", k, 1600);
    check("train_shape_mismatches", mism, 0);
    check("train_done", done, 1);
    check("train_pulse_low", pulse_out, 0);
    rd(4'd8, 8'h00, "cd_h_full");
    rd(4'd9, 8'h32, "cd_l_full");
    rd(4'd7, 8'h00, "ctrl_after_done");
    rd(4'd10, 8'h01, "status_done");

    // Restart, coherent mid-train read, frozen config, abort
    wr(4'd7, 8'h01);
    check("restart_done_clr", done, 0);
    check("restart_pulse", pulse_out, 1);
    repeat (700) @(negedge clk);
    rd(4'd8, 8'h00, "cd_h_mid");
    rd(4'd9, 8'h15, "cd_l_mid");
    check("mid_busy", busy, 1);
    check("mid_pulse", pulse_out, 0);
    wr(4'd1, 8'd8);
    @(negedge clk);
    wr(4'd7, 8'h00);
    check("abort_pulse", pulse_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rd(4'd1, 8'd32, "period_l_frozen");
    rd(4'd8, 8'h00, "cd_h_abort");
    rd(4'd9, 8'h16, "cd_l_abort");
    rd(4'd10, 8'h00, "status_abort");
    rd(4'd7, 8'h00, "ctrl_abort");

    // Invalid config: WIDTH == PERIOD
    wr(4'd3, 8'd32);
    wr(4'd7, 8'h01);
    check("cfgerr_busy", busy, 0);
    check("cfgerr_pulse", pulse_out, 0);
    rd(4'd10, 8'h04, "status_cfgerr");
    rd(4'd7, 8'h00, "ctrl_cfgerr");
    wr(4'd10, 8'h04);
    rd(4'd10, 8'h00, "status_cfgerr_clr");

    // Reserved / unmapped addresses
    wr(4'd6, 8'hAA);
    wr(4'd15, 8'h55);
    rd(4'd6, 8'h00, "reserved_6");
    rd(4'd15, 8'h00, "unmapped_f");

    // Minimum train: PERIOD=2, WIDTH=1, COUNT=1
    wr(4'd1, 8'd2); wr(4'd3, 8'd1); wr(4'd5, 8'd1);
    wr(4'd7, 8'h01);
    check("min_pulse_c0", pulse_out, 1);
    check("min_busy_c0", busy, 1);
    @(negedge clk);
    check("min_pulse_c1", pulse_out, 0);
    check("min_busy_c1", busy, 1);
    @(negedge clk);
    check("min_busy_c2", busy, 0);
    check("min_done_c2", done, 1);
    rd(4'd8, 8'h00, "cd_h_min");
    rd(4'd9, 8'h01, "cd_l_min");
    wr(4'd7, 8'h01);
    check("min_restart_done", done, 0);
    check("min_restart_pulse", pulse_out, 1);
    repeat (2) @(negedge clk);
    check("min_restart_done2", done, 1);
    wr(4'd10, 8'h01);
    check("done_w1c", done, 0);

    // Reset in the middle of a long train
    wr(4'd1, 8'd32); wr(4'd3, 8'd4); wr(4'd5, 8'd50);
    wr(4'd7, 8'h01);
    repeat (2) @(negedge clk);
    check("pre_reset_pulse", pulse_out, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_pulse", pulse_out, 0);
    check("async_reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 11; a++) rd(4'(a), 8'h00, "post_reset_reg");
    check("post_reset_done", done, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
